// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (IDLE -> ACCESS [-> RDWAIT]).
// Tie-break: fixed priority to requester 0 by default; round-robin when ARB_ROUND_ROBIN_EN is defined.
module data_mem_arbiter (
   input  logic        clock,
   input  logic        clear,
   input  logic        req0,
   input  logic        we0,
   input  logic [10:0] addr0,
   input  logic [17:0] wdata0,
   output logic        gnt0,
   output logic        rvalid0,
   output logic [17:0] rdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [10:0] addr1,
   input  logic [17:0] wdata1,
   output logic        gnt1,
   output logic        rvalid1,
   output logic [17:0] rdata1,
   output logic [10:0] mem_addr,
   output logic [17:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [17:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

   state_t      state, state_nxt;
   logic        win;
   logic        lat_we;
   logic [10:0] lat_addr;
   logic [17:0] lat_wdata;
   logic        pick;
   logic        any_req;

   assign any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_gnt;

   // Reset value 1 makes requester 0 win the first tie.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         last_gnt <= 1'b1;
      else if (state == ACCESS)
         last_gnt <= win;
   end

   always_comb begin
      pick = req1;
      if (req0 && req1)
         pick = ~last_gnt;
   end
`else
   assign pick = ~req0;
`endif

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Latched fields double as the memory address/data drivers, so they hold when idle.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         win       <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (state == IDLE && any_req) begin
         win       <= pick;
         lat_we    <= pick ? we1    : we0;
         lat_addr  <= pick ? addr1  : addr0;
         lat_wdata <= pick ? wdata1 : wdata0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = lat_we ? IDLE : RDWAIT;
         RDWAIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      rdata0    = '0;
      rdata1    = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      case (state)
         ACCESS: begin
            gnt0      = ~win;
            gnt1      = win;
            mem_write = lat_we;
            mem_read  = ~lat_we;
         end
         RDWAIT: begin
            rvalid0 = ~win;
            rvalid1 = win;
            if (win)
               rdata1 = mem_rdata;
            else
               rdata0 = mem_rdata;
         end
         default: ;
      endcase
   end

   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (free-slot time, pending read, shadow memory).
module tb_data_mem_arbiter;

   logic        clock = 1'b0;
   logic        clear;
   logic        req0, we0, req1, we1;
   logic [10:0] addr0, addr1;
   logic [17:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [17:0] rdata0, rdata1;
   logic [10:0] mem_addr;
   logic [17:0] mem_wdata;
   logic        mem_write, mem_read;
   logic [17:0] mem_rdata;
   logic        busy;

   int passed = 0;
   int total  = 0;

   logic [17:0] mem [0:2047];
   logic [17:0] mm  [0:2047];

   always #5 clock = ~clock;

   data_mem_arbiter dut (
      .clock(clock), .clear(clear),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Memory with registered read data, one cycle after mem_read.
   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 18'(i * 1237 + 99);
      mem_rdata = '0;
      forever begin
         @(posedge clock);
         if (mem_write) mem[mem_addr] <= mem_wdata;
         if (mem_read)  mem_rdata <= mem[mem_addr];
      end
   end

   task automatic idle_inputs();
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      clear = 1'b1;
   endtask

   task automatic test_reset();
      logic [53:0] outs;
      idle_inputs();
      clear = 1'b0;
      #1;
      outs = {gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read, busy,
              mem_addr, mem_wdata, rdata0, rdata1};
      total++;
      if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
      else passed++;
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;
      total++;
      if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_write();
      @(negedge clock);
      req0 = 1'b1; we0 = 1'b1; addr0 = 11'd5; wdata0 = 18'h2A5A5;
      @(posedge clock); #1;
      total++;
      if ({gnt0, gnt1, mem_write, mem_read, busy, mem_addr, mem_wdata} !==
          {5'b10101, 11'd5, 18'h2A5A5})
         $display("FAIL write_access: got gnt=%b%b w=%b r=%b busy=%b addr=%h data=%h",
                  gnt0, gnt1, mem_write, mem_read, busy, mem_addr, mem_wdata);
      else passed++;
      mm[5] = 18'h2A5A5;
      @(negedge clock);
      req0 = 1'b0;
      @(posedge clock); #1;
      total++;
      if ({gnt0, mem_write, busy, mem_addr, mem_wdata} !== {3'b000, 11'd5, 18'h2A5A5})
         $display("FAIL write_after: got gnt0=%b w=%b busy=%b addr=%h data=%h want 0 0 0 5 2a5a5",
                  gnt0, mem_write, busy, mem_addr, mem_wdata);
      else passed++;
   endtask

   task automatic test_read();
      @(negedge clock);
      req1 = 1'b1; we1 = 1'b0; addr1 = 11'd5;
      @(posedge clock); #1;
      total++;
      if ({gnt1, gnt0, mem_read, mem_write, rvalid1, rvalid0, mem_addr} !== {6'b101000, 11'd5})
         $display("FAIL read_access: got gnt1=%b gnt0=%b r=%b w=%b rv1=%b rv0=%b addr=%h",
                  gnt1, gnt0, mem_read, mem_write, rvalid1, rvalid0, mem_addr);
      else passed++;
      @(negedge clock);
      req1 = 1'b0;
      @(posedge clock); #1;
      total++;
      if ({rvalid1, rvalid0, gnt1, busy, rdata1, rdata0} !== {4'b1001, 18'h2A5A5, 18'h0})
         $display("FAIL read_data: got rv1=%b rv0=%b gnt1=%b busy=%b rdata1=%h rdata0=%h want 1 0 0 1 2a5a5 0",
                  rvalid1, rvalid0, gnt1, busy, rdata1, rdata0);
      else passed++;
      @(posedge clock); #1;
      total++;
      if ({rvalid1, rvalid0, busy, rdata1} !== 21'h0)
         $display("FAIL read_done: got rv1=%b rv0=%b busy=%b rdata1=%h want 0",
                  rvalid1, rvalid0, busy, rdata1);
      else passed++;
   endtask

   task automatic test_tie();
      int seq[$];
      int exp_w;
      do_reset();
      @(negedge clock);
      req0 = 1'b1; we0 = 1'b1; addr0 = 11'd100; wdata0 = 18'h11111;
      req1 = 1'b1; we1 = 1'b1; addr1 = 11'd101; wdata1 = 18'h22222;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); #1;
         if (gnt0 && gnt1) seq.push_back(2);
         else if (gnt0)    seq.push_back(0);
         else if (gnt1)    seq.push_back(1);
      end
      mm[100] = 18'h11111;
      mm[101] = 18'h22222;
      total++;
      if (seq.size() !== 4) $display("FAIL tie_count: got %0d grants want 4", seq.size());
      else passed++;
      for (int i = 0; i < seq.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_w = i % 2;
`else
         exp_w = 0;
`endif
         total++;
         if (seq[i] !== exp_w) $display("FAIL tie_grant_%0d: got %0d want %0d", i, seq[i], exp_w);
         else passed++;
      end
      idle_inputs();
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset_mid_read();
      logic [53:0] outs;
      int bad;
      do_reset();
      @(negedge clock);
      req0 = 1'b1; we0 = 1'b0; addr0 = 11'd5;
      @(posedge clock);
      @(negedge clock);
      req0 = 1'b0;
      @(posedge clock); #1;
      total++;
      if (rvalid0 !== 1'b1) $display("FAIL rst_rd_pre: got rvalid0=%b want 1", rvalid0);
      else passed++;
      #1 clear = 1'b0;
      #1;
      outs = {gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_read, busy,
              mem_addr, mem_wdata, rdata0, rdata1};
      total++;
      if (outs !== '0) $display("FAIL rst_rd_outputs: got %h want 0", outs);
      else passed++;
      @(negedge clock);
      clear = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         if (rvalid0 || rvalid1 || gnt0 || gnt1 || busy) bad++;
      end
      total++;
      if (bad !== 0) $display("FAIL rst_rd_ghost: got %0d active cycles want 0", bad);
      else passed++;
      @(negedge clock);
      req0 = 1'b1; we0 = 1'b1; addr0 = 11'd7; wdata0 = 18'h3FFFF;
      @(posedge clock); #1;
      total++;
      if ({gnt0, mem_write, mem_addr, mem_wdata} !== {2'b11, 11'd7, 18'h3FFFF})
         $display("FAIL rst_rd_first_gnt: got gnt0=%b w=%b addr=%h data=%h want 1 1 7 3ffff",
                  gnt0, mem_write, mem_addr, mem_wdata);
      else passed++;
      mm[7] = 18'h3FFFF;
      @(negedge clock);
      req0 = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_early_withdrawal();
      int g, w, bad;
      g = 0; w = 0; bad = 0;
      @(negedge clock);
      req0 = 1'b1; we0 = 1'b1; addr0 = 11'd3; wdata0 = 18'h00007;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         if (gnt0) g++;
         if (mem_write) begin
            w++;
            if (mem_addr !== 11'd3 || mem_wdata !== 18'h00007) bad++;
         end
         @(negedge clock);
         idle_inputs();
      end
      mm[3] = 18'h00007;
      total++;
      if (g !== 1) $display("FAIL withdraw_gnt: got %0d pulses want 1", g);
      else passed++;
      total++;
      if (w !== 1 || bad !== 0) $display("FAIL withdraw_write: got %0d writes %0d bad want 1 0", w, bad);
      else passed++;
      total++;
      if (mem[3] !== 18'h00007) $display("FAIL withdraw_mem: got %h want 00007", mem[3]);
      else passed++;
   endtask

   task automatic test_random();
      logic        hold [2];
      logic        r_we [2];
      logic [10:0] r_addr [2];
      logic [17:0] r_wd [2];
      logic [1:0]  e_gnt, e_rv;
      logic [17:0] e_rd [2];
      logic        e_mw, e_mr, e_busy;
      logic [10:0] e_addr;
      logic [17:0] e_wd;
      logic        rd_pend, rd_w;
      logic [17:0] rd_data;
      int          last, free_at, w, errs;
      do_reset();
      last = 1; free_at = 0; rd_pend = 1'b0; rd_w = 1'b0; rd_data = '0;
      e_addr = '0; e_wd = '0; errs = 0;
      for (int n = 0; n < 2; n++) begin
         hold[n] = 1'b0; r_we[n] = 1'b0; r_addr[n] = '0; r_wd[n] = '0;
      end
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         for (int n = 0; n < 2; n++) begin
            if (!hold[n] && ($urandom % 3 != 0)) begin
               hold[n]   = 1'b1;
               r_we[n]   = 1'($urandom);
               r_addr[n] = ($urandom % 2 == 0) ? 11'(16 + $urandom % 16) : 11'(2032 + $urandom % 16);
               r_wd[n]   = 18'($urandom);
            end
         end
         req0 = hold[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_wd[0];
         req1 = hold[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_wd[1];
         e_gnt = '0; e_rv = '0; e_rd[0] = '0; e_rd[1] = '0; e_mw = 1'b0; e_mr = 1'b0;
         if (rd_pend) begin
            e_rv[rd_w]   = 1'b1;
            e_rd[rd_w]   = rd_data;
            rd_pend      = 1'b0;
         end
         if (k >= free_at && (hold[0] || hold[1])) begin
            if (hold[0] && hold[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
               w = (last == 0) ? 1 : 0;
`else
               w = 0;
`endif
            end else
               w = hold[1] ? 1 : 0;
            last     = w;
            e_gnt[w] = 1'b1;
            e_mw     = r_we[w];
            e_mr     = !r_we[w];
            e_addr   = r_addr[w];
            e_wd     = r_wd[w];
            if (r_we[w]) begin
               mm[r_addr[w]] = r_wd[w];
               free_at = k + 2;
            end else begin
               rd_pend = 1'b1;
               rd_w    = 1'(w);
               rd_data = mm[r_addr[w]];
               free_at = k + 3;
            end
            hold[w] = 1'b0;
         end
         e_busy = (e_gnt != 0) || (e_rv != 0);
         @(posedge clock); #1;
         total++;
         if ({gnt1, gnt0, rvalid1, rvalid0, mem_write, mem_read, busy} !==
             {e_gnt, e_rv, e_mw, e_mr, e_busy}) begin
            if (errs < 10)
               $display("FAIL rand_ctrl cyc %0d: got %b%b %b%b w=%b r=%b busy=%b want %b %b w=%b r=%b busy=%b",
                        k, gnt1, gnt0, rvalid1, rvalid0, mem_write, mem_read, busy,
                        e_gnt, e_rv, e_mw, e_mr, e_busy);
            errs++;
         end else passed++;
         total++;
         if ({mem_addr, mem_wdata, rdata0, rdata1} !== {e_addr, e_wd, e_rd[0], e_rd[1]}) begin
            if (errs < 10)
               $display("FAIL rand_data cyc %0d: got addr=%h wd=%h rd0=%h rd1=%h want %h %h %h %h",
                        k, mem_addr, mem_wdata, rdata0, rdata1, e_addr, e_wd, e_rd[0], e_rd[1]);
            errs++;
         end else passed++;
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mm[i] = 18'(i * 1237 + 99);
      test_reset();
      test_write();
      test_read();
      test_tie();
      test_reset_mid_read();
      test_early_withdrawal();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
